condicionador_botoes: RTL and testbench
=======================================

Name: condicionador_botoes

Overview:
- Input conditioning stage directly upstream of the game datapath/control: turns raw, asynchronous, bouncing push-button lines into clean, one-cycle play events.
- Synchronizes, debounces and validates the button vector.
- Delivers a registered one-hot `jogada` plus a `jogada_feita` strobe, so the downstream comparator and FSM see exactly one event per physical press.

Parameters:
- N_BOTOES, 4, number of button lines.
- DEBOUNCE, 5, consecutive stable synchronized cycles needed to accept a press or a release. Legal range 2..255; 5 = 5 ms at the 1 kHz system clock.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- botoes  in  N_BOTOES  raw asynchronous button levels, 1 = pressed.
- limpa_jogada  in  1  synchronous clear of the `jogada` register.
- jogada  out  N_BOTOES  registered one-hot code of the last accepted press.
- jogada_feita  out  1  one-cycle pulse, valid press accepted.
- jogada_invalida  out  1  one-cycle pulse, debounced multi-button press rejected.
- tem_jogada  out  1  level, a debounced press is currently held.
- db_estado  out  2  FSM state code, for debug display.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: it is sampled only on the rising edge of `clock`, and when high it overrides all other inputs.

Reset values:
- Synchronizer flops, `amostra`, `cnt` and `jogada` go to 0.
- `jogada_feita`, `jogada_invalida` and `tem_jogada` go to 0.
- State goes to OCIOSO (`db_estado` = 0).

Synchronizer:
- Two flip-flops per line; `sinc` is `botoes` delayed by two edges.
- The FSM uses only `sinc`.

FSM states and codes:
- OCIOSO = 0, FILTRANDO = 1, PRESSIONADO = 2, SOLTANDO = 3.

Transitions:
- OCIOSO:
  - `sinc` != 0 → `amostra` <= `sinc`, `cnt` <= 1, go to FILTRANDO.
  - Otherwise stay.
- FILTRANDO:
  - `sinc` == 0 → go to OCIOSO (glitch discarded).
  - `sinc` != `amostra` and nonzero → `amostra` <= `sinc`, `cnt` <= 1 (restart).
  - `sinc` == `amostra` and `cnt` == DEBOUNCE-1 → accept and go to PRESSIONADO.
  - Otherwise `cnt`++.
- Accept, `amostra` has exactly one bit set:
  - `jogada` <= `amostra`.
  - `jogada_feita` high for exactly the next cycle.
- Accept, two or more bits set:
  - `jogada_invalida` high for one cycle.
  - `jogada` unchanged.
- PRESSIONADO:
  - `tem_jogada` = 1.
  - Nonzero changes of `sinc` are ignored.
  - `sinc` == 0 → `cnt` <= 1, go to SOLTANDO.
- SOLTANDO:
  - `tem_jogada` = 1.
  - `sinc` != 0 → go back to PRESSIONADO (release bounce, no new event).
  - `cnt` == DEBOUNCE-1 → go to OCIOSO.
  - Otherwise `cnt`++.

Latency:
- The `jogada_feita` pulse starts DEBOUNCE+2 rising edges after the first edge that samples a stable raw press. For DEBOUNCE = 5 that is 7 edges.
- `jogada` and `tem_jogada` update on the same edge as the pulse starts.
- `tem_jogada` falls on the edge that enters OCIOSO.

Ordering and boundary conditions:
- A new press is recognized only after the previous release has been debounced.
- Every held press yields at most one `jogada_feita` or `jogada_invalida` pulse.
- `limpa_jogada`: `jogada` <= 0 on the next edge. If it coincides with an accept on the same edge, the accept wins.
- Reset mid-operation (any state): returns to OCIOSO and discards any pending count. A button still held after reset is re-detected as a new press after the full latency.
- `cnt` width is ceil(log2(DEBOUNCE)). `cnt` never exceeds DEBOUNCE-1; no wrap-around.

Test Plan:
Conditions for every scenario: DEBOUNCE = 5, 1 kHz clock, stimulus applied on the falling edge.
1. Reset, then `botoes` = 0001 held for 10 cycles, then released → exactly one `jogada_feita` pulse, 7 edges after the first sampling edge. `jogada` = 0001 and `tem_jogada` = 1 from that same edge. `tem_jogada` returns to 0 7 edges after the release is first sampled, with `db_estado` = 0.
2. `botoes` = 0100 for 3 cycles, 0000 for 1 cycle, then 0100 for 10 cycles → exactly one `jogada_feita` pulse, 7 edges after the re-press is sampled. `jogada` = 0100.
3. `botoes` = 0010 for 2 cycles, then 0000 → no pulse on either strobe. `jogada` keeps its prior value. FSM goes 0 → 1 → 0.
4. `botoes` = 0011 held for 10 cycles → one `jogada_invalida` pulse after 7 edges, `jogada_feita` stays 0, `jogada` unchanged, `tem_jogada` = 1 until the release is debounced.
5. `botoes` = 1000 for 10 cycles, 0000 for 2, 1000 for 2, 0000 for 10 → one `jogada_feita` pulse only, `jogada` = 1000.
6. With `jogada` = 1000: pulse `limpa_jogada` → `jogada` = 0000 next edge. Then hold 0001 and assert `reset` mid-FILTRANDO → all outputs 0. After `reset` falls, a pulse occurs with `jogada` = 0001, 7 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/condicionador_botoes.sv
`default_nettype none
// ============================================================================
// Module      : condicionador_botoes
// Description : Synchronizes, debounces and validates a push-button vector,
//               producing one clean one-hot play event per physical press.
// Revision    : 1.0 - initial release
// ============================================================================
module condicionador_botoes #(
    parameter int N_BOTOES = 4,
    parameter int DEBOUNCE = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                limpa_jogada,
    output logic [N_BOTOES-1:0] jogada,
    output logic                jogada_feita,
    output logic                jogada_invalida,
    output logic                tem_jogada,
    output logic [1:0]          db_estado
);

    localparam int C_CW = $clog2(DEBOUNCE);
    localparam logic [C_CW-1:0]     C_CNT_MAX = C_CW'(DEBOUNCE - 1);
    localparam logic [C_CW-1:0]     C_CNT_UM  = C_CW'(1);
    localparam logic [N_BOTOES-1:0] C_BIT_UM  = N_BOTOES'(1);

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        FILTRANDO   = 2'd1,
        PRESSIONADO = 2'd2,
        SOLTANDO    = 2'd3
    } estado_t;

    logic [N_BOTOES-1:0] r_sinc1;
    logic [N_BOTOES-1:0] r_sinc;
    estado_t             r_estado;
    estado_t             w_estado_prox;
    logic [N_BOTOES-1:0] r_amostra;
    logic [N_BOTOES-1:0] w_amostra_prox;
    logic [C_CW-1:0]     r_cnt;
    logic [C_CW-1:0]     w_cnt_prox;
    logic                w_aceita;
    logic                w_unico;
    logic [N_BOTOES-1:0] r_jogada;
    logic                r_feita;
    logic                r_invalida;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign w_unico = (r_amostra != '0) &&
                     ((r_amostra & (r_amostra - C_BIT_UM)) == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sinc1 <= '0;
            r_sinc  <= '0;
        end else begin
            r_sinc1 <= botoes;
            r_sinc  <= r_sinc1;
        end
    end

    always_comb begin
        w_estado_prox  = r_estado;
        w_amostra_prox = r_amostra;
        w_cnt_prox     = r_cnt;
        w_aceita       = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (r_sinc != '0) begin
                    w_amostra_prox = r_sinc;
                    w_cnt_prox     = C_CNT_UM;
                    w_estado_prox  = FILTRANDO;
                end
            end
            FILTRANDO: begin
                if (r_sinc == '0) begin
                    w_estado_prox = OCIOSO;
                end else if (r_sinc != r_amostra) begin
                    w_amostra_prox = r_sinc;
                    w_cnt_prox     = C_CNT_UM;
                end else if (r_cnt == C_CNT_MAX) begin
                    w_aceita      = 1'b1;
                    w_estado_prox = PRESSIONADO;
                end else begin
                    w_cnt_prox = r_cnt + C_CNT_UM;
                end
            end
            PRESSIONADO: begin
                // Changes between nonzero patterns while held are ignored.
                if (r_sinc == '0) begin
                    w_cnt_prox    = C_CNT_UM;
                    w_estado_prox = SOLTANDO;
                end
            end
            SOLTANDO: begin
                if (r_sinc != '0) begin
                    w_estado_prox = PRESSIONADO;
                end else if (r_cnt == C_CNT_MAX) begin
                    w_estado_prox = OCIOSO;
                end else begin
                    w_cnt_prox = r_cnt + C_CNT_UM;
                end
            end
            default: begin
                w_estado_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= OCIOSO;
            r_amostra  <= '0;
            r_cnt      <= '0;
            r_jogada   <= '0;
            r_feita    <= 1'b0;
            r_invalida <= 1'b0;
        end else begin
            r_estado   <= w_estado_prox;
            r_amostra  <= w_amostra_prox;
            r_cnt      <= w_cnt_prox;
            r_feita    <= w_aceita && w_unico;
            r_invalida <= w_aceita && !w_unico;
            // An accept on the same edge takes priority over the clear.
            if (w_aceita && w_unico) begin
                r_jogada <= r_amostra;
            end else if (limpa_jogada) begin
                r_jogada <= '0;
            end
        end
    end

    assign jogada          = r_jogada;
    assign jogada_feita    = r_feita;
    assign jogada_invalida = r_invalida;
    assign tem_jogada      = (r_estado == PRESSIONADO) || (r_estado == SOLTANDO);
    assign db_estado       = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_condicionador_botoes.sv
`default_nettype none
// ============================================================================
// Module      : tb_condicionador_botoes
// Description : Self-checking bench: vector table, directed corner sequences
//               and random presses against a window-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_condicionador_botoes;

    localparam int DEB = 5;

    logic       clock;
    logic       reset;
    logic [3:0] botoes;
    logic       limpa_jogada;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic       tem_jogada;
    logic [1:0] db_estado;

    condicionador_botoes #(.N_BOTOES(4), .DEBOUNCE(DEB)) dut (
        .clock          (clock),
        .reset          (reset),
        .botoes         (botoes),
        .limpa_jogada   (limpa_jogada),
        .jogada         (jogada),
        .jogada_feita   (jogada_feita),
        .jogada_invalida(jogada_invalida),
        .tem_jogada     (tem_jogada),
        .db_estado      (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: press accepted when the last DEB synchronized samples
    // are one identical nonzero pattern; release when they are all zero.
    logic [3:0] m_s1, m_s2;
    logic [3:0] m_hist [DEB];
    logic       m_held;
    logic       m_feita, m_inval, m_tem;
    logic [3:0] m_jog;
    logic [1:0] m_est;

    int ecnt = 0;
    int n_feita = 0;
    int n_inval = 0;
    int ult_feita = -1;
    int ult_inval = -1;

    typedef struct {
        logic [3:0] b;
        logic       l;
        logic       r;
        logic       f;
        logic       i;
        logic [3:0] j;
        logic       t;
        logic [1:0] e;
    } vetor_t;

    vetor_t tab [23];

    task automatic verifica(input string nome, input int valor, input int esperado);
        total++;
        if (valor != esperado) begin
            bad++;
            $display("FAIL %s at edge %0d: got=%0d expected=%0d", nome, ecnt, valor, esperado);
        end
    endtask

    task automatic modelo_reset();
        m_s1 = '0; m_s2 = '0; m_held = 1'b0;
        m_feita = 1'b0; m_inval = 1'b0; m_tem = 1'b0; m_jog = '0; m_est = 2'd0;
        for (int k = 0; k < DEB; k++) m_hist[k] = '0;
    endtask

    task automatic modelo_passo(input logic [3:0] b, input logic l, input logic r);
        logic [3:0] s;
        logic       iguais;
        logic       aceita_ok;
        if (r) begin
            modelo_reset();
        end else begin
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = b;
            for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = s;
            iguais = 1'b1;
            for (int k = 1; k < DEB; k++) if (m_hist[k] != m_hist[0]) iguais = 1'b0;
            m_feita = 1'b0;
            m_inval = 1'b0;
            aceita_ok = 1'b0;
            if (!m_held) begin
                if (iguais && s != 0) begin
                    m_held = 1'b1;
                    if ($countones(s) == 1) begin
                        m_feita   = 1'b1;
                        aceita_ok = 1'b1;
                    end else begin
                        m_inval = 1'b1;
                    end
                end
            end else if (iguais && s == 0) begin
                m_held = 1'b0;
            end
            if (aceita_ok) m_jog = s;
            else if (l)    m_jog = '0;
            m_tem = m_held;
            if (!m_held) m_est = (s != 0) ? 2'd1 : 2'd0;
            else         m_est = (s != 0) ? 2'd2 : 2'd3;
        end
    endtask

    task automatic passo(input logic [3:0] b, input logic l, input logic r);
        @(negedge clock);
        botoes = b; limpa_jogada = l; reset = r;
        @(posedge clock);
        modelo_passo(b, l, r);
        ecnt++;
        #1;
        verifica("feita_vs_model", jogada_feita, m_feita);
        verifica("invalida_vs_model", jogada_invalida, m_inval);
        verifica("jogada_vs_model", jogada, m_jog);
        verifica("tem_vs_model", tem_jogada, m_tem);
        verifica("estado_vs_model", db_estado, m_est);
        if (jogada_feita)    begin n_feita++; ult_feita = ecnt; end
        if (jogada_invalida) begin n_inval++; ult_inval = ecnt; end
    endtask

    task automatic repete(input logic [3:0] b, input int n);
        for (int k = 0; k < n; k++) passo(b, 1'b0, 1'b0);
    endtask

    int base;
    int r_sel, dur;
    logic [3:0] padrao;

    initial begin
        reset = 1'b1; botoes = '0; limpa_jogada = 1'b0;
        modelo_reset();

        // Scenario 1 (reset, single press, release) and scenario 3 (short glitch).
        tab[0]  = '{4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
        tab[1]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
        tab[2]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
        tab[3]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1};
        tab[4]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1};
        tab[5]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1};
        tab[6]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1};
        tab[7]  = '{4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 2'd2};
        tab[8]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd2};
        tab[9]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd2};
        tab[10] = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd2};
        tab[11] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd2};
        tab[12] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd2};
        tab[13] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd3};
        tab[14] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd3};
        tab[15] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd3};
        tab[16] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd3};
        tab[17] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0};
        tab[18] = '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0};
        tab[19] = '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0};
        tab[20] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd1};
        tab[21] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd1};
        tab[22] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0};

        for (int v = 0; v < 23; v++) begin
            passo(tab[v].b, tab[v].l, tab[v].r);
            verifica("tab_feita", jogada_feita, tab[v].f);
            verifica("tab_invalida", jogada_invalida, tab[v].i);
            verifica("tab_jogada", jogada, tab[v].j);
            verifica("tab_tem", tem_jogada, tab[v].t);
            verifica("tab_estado", db_estado, tab[v].e);
        end

        // Scenario 2: bounce during press, pulse 7 edges after re-press sampled.
        base = ecnt; n_feita = 0; n_inval = 0;
        repete(4'h4, 3); repete(4'h0, 1); repete(4'h4, 10); repete(4'h0, 10);
        verifica("s2_pulsos", n_feita, 1);
        verifica("s2_latencia", ult_feita - base, 5 + 6);
        verifica("s2_jogada", jogada, 4'h4);

        // Scenario 4: two buttons together are rejected.
        base = ecnt; n_feita = 0; n_inval = 0;
        repete(4'h3, 10);
        verifica("s4_tem_segurando", tem_jogada, 1);
        repete(4'h0, 10);
        verifica("s4_invalidas", n_inval, 1);
        verifica("s4_latencia", ult_inval - base, 7);
        verifica("s4_feitas", n_feita, 0);
        verifica("s4_jogada", jogada, 4'h4);
        verifica("s4_tem_solto", tem_jogada, 0);

        // Scenario 5: release bounce yields no second event.
        n_feita = 0; n_inval = 0;
        repete(4'h8, 10); repete(4'h0, 2); repete(4'h8, 2); repete(4'h0, 10);
        verifica("s5_pulsos", n_feita + n_inval, 1);
        verifica("s5_jogada", jogada, 4'h8);

        // Scenario 6: clear, reset mid-filter, re-detection; accept beats clear.
        passo(4'h0, 1'b1, 1'b0);
        verifica("s6_limpa", jogada, 4'h0);
        repete(4'h1, 4);
        verifica("s6_filtrando", db_estado, 1);
        passo(4'h1, 1'b0, 1'b1);
        verifica("s6_reset_est", db_estado, 0);
        verifica("s6_reset_jog", jogada, 0);
        verifica("s6_reset_tem", tem_jogada, 0);
        base = ecnt; n_feita = 0;
        repete(4'h1, 6);
        verifica("s6_sem_pulso_cedo", n_feita, 0);
        passo(4'h1, 1'b1, 1'b0);
        verifica("s6_latencia", ult_feita - base, 7);
        verifica("s6_aceita_vence", jogada, 4'h1);
        repete(4'h1, 3); repete(4'h0, 10);

        // Random presses, bounces, clears and occasional resets.
        for (int seg = 0; seg < 200; seg++) begin
            r_sel = $urandom_range(0, 9);
            if (r_sel <= 5)      padrao = 4'(1 << $urandom_range(0, 3));
            else if (r_sel <= 7) padrao = 4'($urandom_range(0, 15));
            else                 padrao = 4'h0;
            dur = $urandom_range(1, 12);
            for (int k = 0; k < dur; k++)
                passo(padrao, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
